spot_arbiter: RTL

Spotlight controller that owns the single stage spotlight and shares it between three requesters: the active-low touch pads (manual), an external cue port (req/ack handshake), and an internal auto-sweep sequencer. It sits between the mode FSM, which supplies `spot_en` in Speaker/Play modes, and the spotlight driver, which consumes one-hot `spo`. Movement is rate-limited to one position per `STEP_CYC` cycles along the path left–center–right.

---
 rtl/spot_arbiter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/spot_arbiter.sv
// Spotlight arbiter: shares one stage spotlight between touch pads, a cue port and an
// optional auto-sweep sequencer (enabled by defining SPOT_AUTO_SWEEP_EN).
module spot_arbiter #(
  parameter int STEP_CYC  = 4,
  parameter int DWELL_CYC = 8,
  parameter int HOLD_CYC  = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_spot_en,
  input  logic       i_auto_en,
  input  logic       i_tl_n,
  input  logic       i_tc_n,
  input  logic       i_tr_n,
  input  logic       i_cue_req,
  input  logic [1:0] i_cue_pos,
  output logic       o_cue_ack,
  output logic [2:0] o_spo,
  output logic       o_moving,
  output logic [1:0] o_src
);

  localparam logic [1:0] POS_L = 2'b00;
  localparam logic [1:0] POS_C = 2'b01;
  localparam logic [1:0] POS_R = 2'b11;
  localparam logic [1:0] SRC_NONE = 2'b00;
  localparam logic [1:0] SRC_MAN  = 2'b01;
  localparam logic [1:0] SRC_CUE  = 2'b10;
  localparam logic [1:0] SRC_AUTO = 2'b11;

  localparam int SW = $clog2(STEP_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int DW = $clog2(DWELL_CYC + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYC - 1);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  typedef enum logic [1:0] {ST_OFF, ST_IDLE, ST_MOVE} state_t;

  // Path is L-C-R, so any move from an end passes through center
  function automatic logic [1:0] f_step(input logic [1:0] pos, input logic [1:0] tgt);
    if (pos == tgt)        return pos;
    else if (pos == POS_C) return tgt;
    else                   return POS_C;
  endfunction

  function automatic logic [2:0] f_onehot(input logic [1:0] pos);
    case (pos)
      POS_L:   return 3'b100;
      POS_R:   return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  state_t        r_state, w_state_next;
  logic [1:0]    r_pos, w_pos_next;
  logic [1:0]    r_tgt, w_tgt_next;
  logic [SW-1:0] r_step_cnt, w_step_next;
  logic [HW-1:0] r_hold_cnt, w_hold_next;
  logic [1:0]    r_src, w_src_next;
  logic          r_cue_ack, w_ack_next;
  logic [2:0]    r_spo, w_spo_next;
  logic          r_moving, w_moving_next;

  logic       w_man, w_accept, w_dwell_clr, w_auto_fire, w_auto_req;
  logic [1:0] w_man_tgt, w_cue_tgt, w_auto_tgt, w_req_tgt, w_req_src, w_eff_tgt, w_stepped;

  assign w_man     = ~(i_tl_n & i_tc_n & i_tr_n);
  assign w_man_tgt = !i_tl_n ? POS_L : (!i_tc_n ? POS_C : POS_R);
  assign w_cue_tgt = (i_cue_pos == 2'b10) ? POS_C : i_cue_pos;

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_tgt_next   = r_tgt;
    w_step_next  = r_step_cnt;
    w_hold_next  = r_hold_cnt;
    w_src_next   = r_src;
    w_ack_next   = 1'b0;
    w_dwell_clr  = 1'b0;
    w_auto_fire  = 1'b0;
    w_accept     = 1'b0;
    w_req_tgt    = r_tgt;
    w_req_src    = r_src;
    w_eff_tgt    = r_tgt;
    w_stepped    = r_pos;
    if (!i_spot_en) begin
      w_state_next = ST_OFF;
    end else begin
      case (r_state)
        ST_OFF: begin
          w_state_next = ST_IDLE;
          w_pos_next   = POS_C;
          w_tgt_next   = POS_C;
          w_src_next   = SRC_NONE;
          w_step_next  = '0;
          w_dwell_clr  = 1'b1;
        end
        ST_IDLE: begin
          if (w_man) begin
            w_accept    = 1'b1;
            w_req_tgt   = w_man_tgt;
            w_req_src   = SRC_MAN;
            w_hold_next = HOLD_INIT;
          end else begin
            if (r_hold_cnt != '0) w_hold_next = r_hold_cnt - HOLD_ONE;
            // The ack cycle itself is skipped so a held cue_req is not latched twice
            if (i_cue_req && !r_cue_ack) begin
              w_accept   = 1'b1;
              w_req_tgt  = w_cue_tgt;
              w_req_src  = SRC_CUE;
              w_ack_next = 1'b1;
            end else if (w_auto_req) begin
              w_accept    = 1'b1;
              w_req_tgt   = w_auto_tgt;
              w_req_src   = SRC_AUTO;
              w_auto_fire = 1'b1;
            end
          end
          if (w_accept) begin
            w_dwell_clr = 1'b1;
            w_tgt_next  = w_req_tgt;
            if (w_req_tgt != r_pos) begin
              w_state_next = ST_MOVE;
              w_step_next  = '0;
              w_src_next   = w_req_src;
            end
          end
        end
        ST_MOVE: begin
          if (w_man) begin
            w_tgt_next  = w_man_tgt;
            w_src_next  = SRC_MAN;
            w_hold_next = HOLD_INIT;
            w_dwell_clr = 1'b1;
            w_eff_tgt   = w_man_tgt;
          end
          w_stepped = f_step(r_pos, w_eff_tgt);
          if (w_man && (w_man_tgt == r_pos)) begin
            w_state_next = ST_IDLE;
          end else if (r_step_cnt == STEP_LAST) begin
            w_pos_next  = w_stepped;
            w_step_next = '0;
            if (w_stepped == w_eff_tgt) begin
              w_state_next = ST_IDLE;
              w_dwell_clr  = 1'b1;
            end
          end else begin
            w_step_next = r_step_cnt + STEP_ONE;
          end
        end
        default: w_state_next = ST_OFF;
      endcase
    end
    w_spo_next    = (w_state_next == ST_OFF) ? 3'b000 : f_onehot(w_pos_next);
    w_moving_next = (w_state_next == ST_MOVE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_OFF;
      r_pos      <= POS_C;
      r_tgt      <= POS_C;
      r_step_cnt <= '0;
      r_hold_cnt <= '0;
      r_src      <= SRC_NONE;
      r_cue_ack  <= 1'b0;
      r_spo      <= 3'b000;
      r_moving   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pos      <= w_pos_next;
      r_tgt      <= w_tgt_next;
      r_step_cnt <= w_step_next;
      r_hold_cnt <= w_hold_next;
      r_src      <= w_src_next;
      r_cue_ack  <= w_ack_next;
      r_spo      <= w_spo_next;
      r_moving   <= w_moving_next;
    end
  end

`ifdef SPOT_AUTO_SWEEP_EN
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
  localparam logic [DW-1:0] DWELL_ONE  = DW'(1);

  logic [DW-1:0] r_dwell_cnt;
  logic          r_dir;  // 1 = rightward

  assign w_auto_req = i_auto_en && (r_hold_cnt == '0) && (r_dwell_cnt == DWELL_LAST);
  assign w_auto_tgt = (r_pos == POS_C) ? (r_dir ? POS_R : POS_L) : POS_C;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dwell_cnt <= '0;
      r_dir       <= 1'b1;
    end else begin
      if (w_dwell_clr)
        r_dwell_cnt <= '0;
      else if (r_state == ST_IDLE && i_spot_en && r_dwell_cnt != DWELL_LAST)
        r_dwell_cnt <= r_dwell_cnt + DWELL_ONE;
      if (w_auto_fire) begin
        if (r_pos == POS_L)      r_dir <= 1'b1;
        else if (r_pos == POS_R) r_dir <= 1'b0;
      end
    end
  end
`else
  logic w_unused_auto;
  assign w_auto_req    = i_auto_en & 1'b0;
  assign w_auto_tgt    = POS_C;
  assign w_unused_auto = w_dwell_clr ^ w_auto_fire;
`endif

  assign o_cue_ack = r_cue_ack;
  assign o_spo     = r_spo;
  assign o_moving  = r_moving;
  assign o_src     = r_src;

endmodule
